// File: rtl/cpuy_pkg.sv
// cpuy_pkg: shared fetch-stage state encoding and opcode constants.
package cpuy_pkg;
    typedef enum logic [2:0] {ST_FETCH, ST_OPCODE, ST_ARG, ST_ISSUE, ST_HALT} fetch_state_e;
    localparam int LONG_OP_BIT = 7;
    localparam logic [7:0] HALT_OPCODE = 8'hFF;
    localparam logic [7:0] OPERAND_NONE = 8'h00;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: fetches 1/2-byte instructions from synchronous program memory for the decoder.
// Define FETCH_HALT_EN to make opcode 0xFF a one-byte HALT that stops fetch until reset.
module fetch_unit
    import cpuy_pkg::*;
#(
    parameter int PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [PC_WIDTH-1:0] pm_addr,
    output logic                pm_rd,
    input  logic [7:0]          pm_rdata,
    output logic [7:0]          opcode,
    output logic [7:0]          operand,
    output logic [PC_WIDTH-1:0] instr_pc,
    output logic                instr_valid,
    input  logic                instr_ready,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                halted
);
    fetch_state_e state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d, instr_pc_q, instr_pc_d;
    logic [7:0] opcode_q, opcode_d, operand_q, operand_d;
    logic is_long, is_halt_op;

`ifdef FETCH_HALT_EN
    assign is_halt_op = opcode_q == HALT_OPCODE;
    assign is_long = pm_rdata[LONG_OP_BIT] && pm_rdata != HALT_OPCODE;
    assign halted = state_q == ST_HALT;
`else
    assign is_halt_op = 1'b0;
    assign is_long = pm_rdata[LONG_OP_BIT];
    assign halted = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d = pc_q;
        opcode_d = opcode_q;
        operand_d = operand_q;
        instr_pc_d = instr_pc_q;
        case (state_q)
            ST_FETCH: state_d = ST_OPCODE;
            ST_OPCODE: begin
                opcode_d = pm_rdata;
                operand_d = OPERAND_NONE;
                instr_pc_d = pc_q;
                pc_d = pc_q + 1'b1;
                state_d = is_long ? ST_ARG : ST_ISSUE;
            end
            ST_ARG: begin
                operand_d = pm_rdata;
                pc_d = pc_q + 1'b1;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                // a halt handshake swallows any redirect so the halt is final
                if (instr_ready) begin
                    state_d = is_halt_op ? ST_HALT : ST_FETCH;
                    pc_d = (redirect_valid && !is_halt_op) ? redirect_pc : pc_q;
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            pc_q <= RESET_PC;
            opcode_q <= OPERAND_NONE;
            operand_q <= OPERAND_NONE;
            instr_pc_q <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            opcode_q <= opcode_d;
            operand_q <= operand_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    // reads must stay quiet while reset is held even though the state sits in FETCH
    assign pm_rd = rst_n && (state_q == ST_FETCH || (state_q == ST_OPCODE && is_long));
    assign pm_addr = state_q == ST_OPCODE ? pc_q + 1'b1 : pc_q;
    assign opcode = opcode_q;
    assign operand = operand_q;
    assign instr_pc = instr_pc_q;
    assign instr_valid = state_q == ST_ISSUE;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against an instruction-level model.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] pm_addr, pm_rdata, opcode, operand, instr_pc, redirect_pc;
    logic pm_rd, instr_valid, halted;
    logic instr_ready = 1'b0;
    logic redirect_valid = 1'b0;
    logic [7:0] mem [256];
    logic [7:0] m_pc;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_unit #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .pm_addr(pm_addr), .pm_rd(pm_rd), .pm_rdata(pm_rdata),
        .opcode(opcode), .operand(operand), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halted(halted)
    );

    always @(posedge clk) if (pm_rd) pm_rdata <= mem[pm_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge while the DUT should be fetching m_pc; leaves one negedge after the handshake.
    task automatic run_instr(input int stall, input bit redir, input logic [7:0] tgt);
        logic [7:0] ipc, nxt, op, arg;
        bit long_i, hlt;
        int n;
        ipc = m_pc;
        nxt = ipc + 8'd1;
        op = mem[ipc];
`ifdef FETCH_HALT_EN
        hlt = op == 8'hFF;
`else
        hlt = 1'b0;
`endif
        long_i = op[7] && !hlt;
        arg = long_i ? mem[nxt] : 8'h00;
        chk("fetch_rd", 32'(pm_rd), 32'd1);
        chk("fetch_addr", 32'(pm_addr), 32'(ipc));
        chk("halted_run", 32'(halted), 32'd0);
        n = 0;
        instr_ready = 1'($urandom);
        redirect_valid = 1'($urandom);
        redirect_pc = 8'($urandom);
        while (!instr_valid && n < 8) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk("arg_rd", 32'(pm_rd), 32'(long_i));
                if (long_i) chk("arg_addr", 32'(pm_addr), 32'(nxt));
            end
            instr_ready = 1'($urandom);
            redirect_valid = 1'($urandom);
            redirect_pc = 8'($urandom);
        end
        chk("latency", 32'(n), long_i ? 32'd3 : 32'd2);
        for (int i = 0; i <= stall; i++) begin
            if (i > 0) @(negedge clk);
            chk("valid", 32'(instr_valid), 32'd1);
            chk("opcode", 32'(opcode), 32'(op));
            chk("operand", 32'(operand), 32'(arg));
            chk("instr_pc", 32'(instr_pc), 32'(ipc));
            chk("issue_rd", 32'(pm_rd), 32'd0);
            instr_ready = i == stall;
            redirect_valid = i == stall ? redir : 1'($urandom);
            redirect_pc = i == stall ? tgt : 8'($urandom);
        end
        @(negedge clk);
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        m_pc = (redir && !hlt) ? tgt : ipc + (long_i ? 8'd2 : 8'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        redirect_pc = 8'h00;
        #2;
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_rd", 32'(pm_rd), 32'd0);
        chk("rst_addr", 32'(pm_addr), 32'h00);
        chk("rst_opcode", 32'(opcode), 32'h00);
        chk("rst_operand", 32'(operand), 32'h00);
        chk("rst_instr_pc", 32'(instr_pc), 32'h00);
        chk("rst_halted", 32'(halted), 32'd0);
        mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h85; mem[3] = 8'h3C; mem[4] = 8'h07;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        m_pc = 8'h00;
        run_instr(0, 1'b0, 8'h00);
        run_instr(0, 1'b0, 8'h00);
        run_instr(0, 1'b0, 8'h00);
        run_instr(5, 1'b1, 8'h40);
        mem[8'h40] = 8'h11; mem[8'hFF] = 8'h90; mem[8'h00] = 8'hAB; mem[8'h01] = 8'h9A; mem[8'h02] = 8'h55;
        run_instr(0, 1'b1, 8'hFF);
        run_instr(1, 1'b0, 8'h00);
        chk("wrap_pc", 32'(m_pc), 32'h01);
        // reset while the operand byte is being captured
        @(negedge clk);
        @(negedge clk);
        chk("arg_valid", 32'(instr_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(instr_valid), 32'd0);
        chk("mid_rst_rd", 32'(pm_rd), 32'd0);
        chk("mid_rst_addr", 32'(pm_addr), 32'h00);
        chk("mid_rst_instr_pc", 32'(instr_pc), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        m_pc = 8'h00;
        run_instr(0, 1'b0, 8'h00);
        run_instr(2, 1'b1, 8'h80);
        mem[8'h80] = 8'hFF; mem[8'h81] = 8'h77;
`ifndef FETCH_HALT_EN
        run_instr(0, 1'b0, 8'h00);
        chk("ff_long_pc", 32'(m_pc), 32'h82);
`endif
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
`ifdef FETCH_HALT_EN
            if (mem[i] == 8'hFF) mem[i] = 8'hFE;
`endif
        end
        for (int k = 0; k < 40; k++) run_instr($urandom_range(0, 3), $urandom_range(0, 3) == 0, 8'($urandom));
`ifdef FETCH_HALT_EN
        mem[m_pc] = 8'h01; mem[8'(m_pc + 8'd1)] = 8'hFF; mem[8'(m_pc + 8'd2)] = 8'h02;
        run_instr(0, 1'b0, 8'h00);
        run_instr(1, 1'b1, 8'h40);
        for (int i = 0; i < 4; i++) begin
            instr_ready = 1'b1;
            chk("halt_flag", 32'(halted), 32'd1);
            chk("halt_valid", 32'(instr_valid), 32'd0);
            chk("halt_rd", 32'(pm_rd), 32'd0);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        chk("halt_rst", 32'(halted), 32'd0);
        rst_n = 1'b1;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
